// File: rtl/fod_dtc_if.sv
// Bus between the frequency-control register side and fod_dtc_ctrl.
// Carries the run enable and frequency/gain settings (master side) and the
// per-period divide ratio, DTC code, update tick and valid flag (slave side).
// Ports:
//   EN, FCW_I[IW], FCW_F[FW], KDTC[DW]   master -> slave
//   DIV[IW+1], DCW[DW], TICK, VLD        slave  -> master
interface fod_dtc_if #(
    parameter int FW = 16,
    parameter int IW = 6,
    parameter int DW = 10
);
    logic          EN;
    logic [IW-1:0] FCW_I;
    logic [FW-1:0] FCW_F;
    logic [DW-1:0] KDTC;
    logic [IW:0]   DIV;
    logic [DW-1:0] DCW;
    logic          TICK;
    logic          VLD;

    modport master (output EN, FCW_I, FCW_F, KDTC,
                    input  DIV, DCW, TICK, VLD);
    modport slave  (input  EN, FCW_I, FCW_F, KDTC,
                    output DIV, DCW, TICK, VLD);
endinterface

// File: rtl/fod_dtc_ctrl.sv
// Purpose: fractional phase accumulator producing per-output-period divide
//          ratio DIV and DTC delay code DCW for the FOD integer divider + DTC.
// Latency: first update 1 cycle after EN sampled high; then one update every DIV cycles.
// Backpressure: none; outputs are level-valid (VLD) and the consumer samples at TICK.
// Ports:
//   CKIN  - input clock, all state on posedge
//   NRST  - asynchronous active-low reset
//   bus   - fod_dtc_if.slave: EN/FCW_I/FCW_F/KDTC in, DIV/DCW/TICK/VLD out
// Optional feature: define DTC_DITHER_EN to add a 16-bit LFSR truncation
// dither on DCW (x^16+x^14+x^13+x^11+1, seed 16'hACE1).
module fod_dtc_ctrl #(
    parameter int FW = 16,
    parameter int IW = 6,
    parameter int DW = 10
) (
    input  logic        CKIN,
    input  logic        NRST,
    fod_dtc_if.slave    bus
);
    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    state_t        r_state;
    logic [FW-1:0] r_acc;
    logic [IW:0]   r_cnt;
    logic [IW-1:0] r_fcw_i;
    logic [FW-1:0] r_fcw_f;
    logic [DW-1:0] r_kdtc;
    logic [IW:0]   r_div;
    logic [DW-1:0] r_dcw;
    logic          r_tick;
    logic          r_vld;

    logic [IW-1:0]    w_fcw_i_clamp;
    logic [IW-1:0]    w_int;
    logic [FW-1:0]    w_frac;
    logic [DW-1:0]    w_kdtc;
    logic [FW-1:0]    w_acc_src;
    logic [FW:0]      w_sum;
    logic [FW+DW-1:0] w_prod;
    logic [IW:0]      w_div;
    logic [DW-1:0]    w_dcw;
    logic             w_upd;

    // Ratios below 2 cannot be produced by the divider; clamp on capture.
    assign w_fcw_i_clamp = (bus.FCW_I < IW'(2)) ? IW'(2) : bus.FCW_I;

    // The first update (in IDLE) works on the live inputs with ACC=0; in RUN
    // the frozen shadow copies and the running accumulator are used.
    assign w_int     = (r_state == ST_IDLE) ? w_fcw_i_clamp : r_fcw_i;
    assign w_frac    = (r_state == ST_IDLE) ? bus.FCW_F     : r_fcw_f;
    assign w_kdtc    = (r_state == ST_IDLE) ? bus.KDTC      : r_kdtc;
    assign w_acc_src = (r_state == ST_IDLE) ? '0            : r_acc;

    assign w_sum  = {1'b0, w_acc_src} + {1'b0, w_frac};
    assign w_prod = {{DW{1'b0}}, w_sum[FW-1:0]} * {{FW{1'b0}}, w_kdtc};
    assign w_div  = {1'b0, w_int} + {{IW{1'b0}}, w_sum[FW]};
    assign w_upd  = (r_cnt == (r_div - (IW+1)'(1)));

`ifdef DTC_DITHER_EN
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    logic [15:0]       r_lfsr;
    logic              w_lfsr_fb;
    logic [FW+DW:0]    w_dsum;

    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    // Adding a uniform value below 2^FW before truncating turns the fixed
    // truncation bias into noise with the exact fractional mean.
    assign w_dsum = {1'b0, w_prod} + {{(FW+DW+1-16){1'b0}}, r_lfsr};
    assign w_dcw  = w_dsum[FW+DW-1:FW];

    always_ff @(posedge CKIN or negedge NRST) begin
        if (!NRST) begin
            r_lfsr <= LFSR_SEED;
        end else if (r_state == ST_RUN && !bus.EN) begin
            r_lfsr <= LFSR_SEED;
        end else if ((r_state == ST_IDLE && bus.EN) || (r_state == ST_RUN && w_upd)) begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end
`else
    assign w_dcw = w_prod[FW+DW-1:FW];
`endif

    always_ff @(posedge CKIN or negedge NRST) begin
        if (!NRST) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_fcw_i <= '0;
            r_fcw_f <= '0;
            r_kdtc  <= '0;
            r_div   <= '0;
            r_dcw   <= '0;
            r_tick  <= 1'b0;
            r_vld   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.EN) begin
                        r_fcw_i <= w_fcw_i_clamp;
                        r_fcw_f <= bus.FCW_F;
                        r_kdtc  <= bus.KDTC;
                        r_acc   <= w_sum[FW-1:0];
                        r_div   <= w_div;
                        r_dcw   <= w_dcw;
                        r_cnt   <= '0;
                        r_tick  <= 1'b1;
                        r_vld   <= 1'b1;
                        r_state <= ST_RUN;
                    end else begin
                        r_tick  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (!bus.EN) begin
                        // Stopping clears everything so a restart begins from ACC=0.
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_div   <= '0;
                        r_dcw   <= '0;
                        r_tick  <= 1'b0;
                        r_vld   <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (w_upd) begin
                        r_acc   <= w_sum[FW-1:0];
                        r_div   <= w_div;
                        r_dcw   <= w_dcw;
                        r_cnt   <= '0;
                        r_tick  <= 1'b1;
                    end else begin
                        r_cnt   <= r_cnt + (IW+1)'(1);
                        r_tick  <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.DIV  = r_div;
    assign bus.DCW  = r_dcw;
    assign bus.TICK = r_tick;
    assign bus.VLD  = r_vld;
endmodule

// File: tb/tb_fod_dtc_ctrl.sv
// Directed bench for fod_dtc_ctrl: reset, integer ratio, fractional sequence,
// clamp, shadow freeze, EN drop/restart and long-run DCW mean.
module tb_fod_dtc_ctrl;
    localparam int FW = 16;
    localparam int IW = 6;
    localparam int DW = 10;

    logic CKIN = 1'b0;
    logic NRST;
    int   n_chk  = 0;
    int   n_fail = 0;

    int tick_cyc[$];
    int tick_div[$];
    int tick_dcw[$];

    fod_dtc_if #(.FW(FW), .IW(IW), .DW(DW)) bus ();

    fod_dtc_ctrl #(.FW(FW), .IW(IW), .DW(DW)) dut (
        .CKIN (CKIN),
        .NRST (NRST),
        .bus  (bus)
    );

    always #5 CKIN = ~CKIN;

    // Records cycle index, DIV and DCW of every TICK over a fixed window.
    task automatic collect(input int ncyc);
        tick_cyc.delete();
        tick_div.delete();
        tick_dcw.delete();
        for (int c = 0; c < ncyc; c++) begin
            @(negedge CKIN);
            if (bus.TICK === 1'b1) begin
                tick_cyc.push_back(c);
                tick_div.push_back(int'(bus.DIV));
                tick_dcw.push_back(int'(bus.DCW));
            end
        end
    endtask

    task automatic go_idle();
        bus.EN = 1'b0;
        repeat (2) @(negedge CKIN);
    endtask

    task automatic start(input int fi, input int ff, input int kd);
        bus.FCW_I = IW'(fi);
        bus.FCW_F = FW'(ff);
        bus.KDTC  = DW'(kd);
        bus.EN    = 1'b1;
    endtask

    task automatic test_reset();
        NRST = 1'b0;
        start(4, 0, 500);
        repeat (3) @(negedge CKIN);
        n_chk++; if (bus.DIV !== 7'd0)   begin n_fail++; $display("FAIL reset_div got %0d want 0", bus.DIV); end
        n_chk++; if (bus.DCW !== 10'd0)  begin n_fail++; $display("FAIL reset_dcw got %0d want 0", bus.DCW); end
        n_chk++; if (bus.TICK !== 1'b0)  begin n_fail++; $display("FAIL reset_tick got %b want 0", bus.TICK); end
        n_chk++; if (bus.VLD !== 1'b0)   begin n_fail++; $display("FAIL reset_vld got %b want 0", bus.VLD); end
        NRST = 1'b1;
        @(negedge CKIN);
        n_chk++; if (bus.TICK !== 1'b1 || bus.VLD !== 1'b1 || bus.DIV !== 7'd4)
            begin n_fail++; $display("FAIL reset_release tick=%b vld=%b div=%0d want 1 1 4", bus.TICK, bus.VLD, bus.DIV); end
        @(negedge CKIN);
        #2 NRST = 1'b0;
        #1;
        n_chk++; if (bus.VLD !== 1'b0 || bus.DIV !== 7'd0)
            begin n_fail++; $display("FAIL async_reset vld=%b div=%0d want 0 0", bus.VLD, bus.DIV); end
        bus.EN = 1'b0;
        @(negedge CKIN);
        NRST = 1'b1;
        @(negedge CKIN);
    endtask

    task automatic test_integer();
        start(4, 0, 500);
        collect(20);
        n_chk++; if (tick_cyc.size() != 5)
            begin n_fail++; $display("FAIL int_tick_count got %0d want 5", tick_cyc.size()); end
        for (int k = 0; k < tick_cyc.size(); k++) begin
            n_chk++; if (tick_cyc[k] != 4*k || tick_div[k] != 4 || tick_dcw[k] != 0)
                begin n_fail++; $display("FAIL int_tick%0d cyc=%0d div=%0d dcw=%0d want %0d 4 0", k, tick_cyc[k], tick_div[k], tick_dcw[k], 4*k); end
        end
        n_chk++; if (bus.VLD !== 1'b1) begin n_fail++; $display("FAIL int_vld got %b want 1", bus.VLD); end
        go_idle();
    endtask

    task automatic test_frac();
        int exp_dcw[4] = '{200, 400, 600, 0};
        int exp_div[4] = '{4, 4, 4, 5};
        start(4, 16'h4000, 800);
        collect(40);
        n_chk++; if (tick_cyc.size() != 10)
            begin n_fail++; $display("FAIL frac_tick_count got %0d want 10", tick_cyc.size()); end
        for (int k = 0; k < 9 && k + 1 < tick_cyc.size(); k++) begin
            n_chk++;
            if (tick_dcw[k] != exp_dcw[k%4] || tick_div[k] != exp_div[k%4] ||
                tick_cyc[k+1] - tick_cyc[k] != exp_div[k%4])
                begin n_fail++; $display("FAIL frac_tick%0d dcw=%0d div=%0d gap=%0d want %0d %0d %0d", k, tick_dcw[k], tick_div[k], tick_cyc[k+1]-tick_cyc[k], exp_dcw[k%4], exp_div[k%4], exp_div[k%4]); end
        end
        go_idle();
    endtask

    task automatic test_clamp();
        start(1, 16'h8000, 1000);
        collect(30);
        n_chk++; if (tick_cyc.size() != 12)
            begin n_fail++; $display("FAIL clamp_tick_count got %0d want 12", tick_cyc.size()); end
        for (int k = 0; k < 11 && k + 1 < tick_cyc.size(); k++) begin
            n_chk++;
            if (tick_div[k] != ((k%2 == 0) ? 2 : 3) || tick_dcw[k] != ((k%2 == 0) ? 500 : 0) ||
                tick_cyc[k+1] - tick_cyc[k] != tick_div[k] || tick_cyc[k+1] - tick_cyc[k] < 2)
                begin n_fail++; $display("FAIL clamp_tick%0d div=%0d dcw=%0d gap=%0d", k, tick_div[k], tick_dcw[k], tick_cyc[k+1]-tick_cyc[k]); end
        end
        go_idle();
    endtask

    task automatic test_shadow();
        start(4, 16'h4000, 800);
        @(negedge CKIN);
        // Changes while running must not take effect.
        bus.FCW_I = 6'd7;
        bus.FCW_F = 16'h8000;
        bus.KDTC  = 10'd100;
        collect(13);
        n_chk++;
        if (tick_cyc.size() != 3 || tick_cyc[0] != 3 || tick_dcw[0] != 400 || tick_dcw[1] != 600 ||
            tick_dcw[2] != 0 || tick_div[2] != 5 || tick_cyc[2] != 11)
            begin n_fail++; $display("FAIL shadow_frozen ticks=%0d want 3 with dcw 400,600,0 div5 at 11", tick_cyc.size()); end
        go_idle();
    endtask

    task automatic test_en_drop();
        start(4, 16'h4000, 800);
        @(negedge CKIN);
        repeat (4) @(negedge CKIN);
        n_chk++; if (bus.TICK !== 1'b1 || bus.DCW !== 10'd400)
            begin n_fail++; $display("FAIL drop_second_tick tick=%b dcw=%0d want 1 400", bus.TICK, bus.DCW); end
        bus.EN = 1'b0;
        @(negedge CKIN);
        n_chk++; if (bus.DIV !== 7'd0 || bus.DCW !== 10'd0 || bus.TICK !== 1'b0 || bus.VLD !== 1'b0)
            begin n_fail++; $display("FAIL drop_outputs div=%0d dcw=%0d tick=%b vld=%b want all 0", bus.DIV, bus.DCW, bus.TICK, bus.VLD); end
        bus.EN = 1'b1;
        @(negedge CKIN);
        n_chk++; if (bus.DCW !== 10'd200 || bus.TICK !== 1'b1 || bus.DIV !== 7'd4 || bus.VLD !== 1'b1)
            begin n_fail++; $display("FAIL drop_restart dcw=%0d tick=%b div=%0d want 200 1 4", bus.DCW, bus.TICK, bus.DIV); end
        go_idle();
    endtask

    task automatic test_long_mean();
        int n = 0;
        int sum = 0;
        int dmax = 0;
        start(4, 16'h4000, 800);
        for (int c = 0; c < 20000 && n < 4096; c++) begin
            @(negedge CKIN);
            if (bus.TICK === 1'b1) begin
                sum += int'(bus.DCW);
                n++;
            end
        end
        n_chk++; if (n != 4096) begin n_fail++; $display("FAIL mean_updates got %0d want 4096", n); end
        n_chk++; if (sum < 299*4096 || sum > 301*4096)
            begin n_fail++; $display("FAIL mean_dcw sum=%0d want %0d..%0d", sum, 299*4096, 301*4096); end
        go_idle();
        n = 0;
        start(4, 16'h4000, 0);
        for (int c = 0; c < 200; c++) begin
            @(negedge CKIN);
            if (bus.TICK === 1'b1) begin
                n++;
                if (int'(bus.DCW) > dmax) dmax = int'(bus.DCW);
            end
        end
        n_chk++; if (n < 40 || dmax != 0)
            begin n_fail++; $display("FAIL kdtc_zero ticks=%0d max_dcw=%0d want >=40 0", n, dmax); end
        go_idle();
    endtask

    initial begin
        NRST      = 1'b0;
        bus.EN    = 1'b0;
        bus.FCW_I = '0;
        bus.FCW_F = '0;
        bus.KDTC  = '0;
        @(negedge CKIN);
        test_reset();
        test_integer();
        test_frac();
        test_clamp();
        test_shadow();
        test_en_drop();
        test_long_mean();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
